encoder_16x4_seq: RTL and testbench



---
 rtl/encoder_16x4_seq_pkg.sv | 21 ++
 rtl/encoder_16x4_seq_if.sv | 24 ++
 rtl/encoder_16x4_seq_prienc.sv | 19 +
 rtl/encoder_16x4_seq.sv | 107 ++++++++++
 tb/tb_encoder_16x4_seq.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/encoder_16x4_seq_pkg.sv
// Shared constants, state encoding and helpers for the sequential 16-to-4 encoder.
package encoder_pkg;

    localparam int WIDTH  = 16;
    localparam int CODE_W = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } enc_state_t;

    function automatic logic [CODE_W:0] popcount16(input logic [0:WIDTH-1] vec);
        logic [CODE_W:0] cnt;
        cnt = 5'd0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + {4'd0, vec[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/encoder_16x4_seq_if.sv
// Request-in / code-out handshake bundle between the encoder and its neighbours.
interface encoder_16x4_seq_if;
    import encoder_pkg::*;

    logic [0:WIDTH-1]  D;
    logic              in_valid;
    logic              in_ready;
    logic [CODE_W-1:0] out_code;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [CODE_W:0]   out_remaining;
    logic              empty_pulse;

    modport master (
        output D, in_valid, out_ready,
        input  in_ready, out_code, out_valid, out_last, out_remaining, empty_pulse
    );

    modport slave (
        input  D, in_valid, out_ready,
        output in_ready, out_code, out_valid, out_last, out_remaining, empty_pulse
    );
endinterface

// File: rtl/encoder_16x4_seq_prienc.sv
// Combinational lowest-index-first priority encoder over a [0:15] vector.
module priority_encoder_16x4
    import encoder_pkg::*;
(
    input  logic [0:WIDTH-1]  vec,
    output logic [CODE_W-1:0] idx,
    output logic              any
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        idx = 4'd0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            idx = vec[i] ? CODE_W'(i) : idx;
        end
        any = |vec;
    end

endmodule

// File: rtl/encoder_16x4_seq.sv
// Sequential 16-to-4 encoder: accepts a request vector and emits the index of
// every set line, lowest first, one code per output handshake.
module encoder_16x4_seq
    import encoder_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    encoder_16x4_seq_if.slave bus
);

    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_EMIT = EMIT;

    logic [0:0]        state_r;
    logic [0:WIDTH-1]  pend_r;
    logic [0:WIDTH-1]  masked_s;
    logic [CODE_W-1:0] code_r;
    logic [CODE_W-1:0] d_idx_s;
    logic [CODE_W-1:0] nxt_idx_s;
    logic              d_any_s;
    logic              nxt_any_s;
    logic              valid_r;
    logic              last_r;
    logic              empty_r;
    logic [CODE_W:0]   remaining_r;
    logic [CODE_W:0]   d_pop_s;

    // Pending lines with the currently presented code removed.
    always_comb begin
        masked_s         = pend_r;
        masked_s[code_r] = 1'b0;
    end

    assign d_pop_s = popcount16(bus.D);

    priority_encoder_16x4 u_load_enc (
        .vec (bus.D),
        .idx (d_idx_s),
        .any (d_any_s)
    );

    priority_encoder_16x4 u_next_enc (
        .vec (masked_s),
        .idx (nxt_idx_s),
        .any (nxt_any_s)
    );

    // Control FSM, pending register and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            pend_r      <= 16'd0;
            code_r      <= 4'd0;
            valid_r     <= 1'b0;
            last_r      <= 1'b0;
            remaining_r <= 5'd0;
            empty_r     <= 1'b0;
        end else begin
            empty_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        if (d_any_s) begin
                            pend_r      <= bus.D;
                            code_r      <= d_idx_s;
                            remaining_r <= d_pop_s;
                            last_r      <= (d_pop_s == 5'd1);
                            valid_r     <= 1'b1;
                            state_r     <= ST_EMIT;
                        end else begin
                            empty_r <= 1'b1;
                        end
                    end
                end
                ST_EMIT: begin
                    if (bus.out_ready) begin
                        pend_r <= masked_s;
                        // An empty remainder also terminates, so a corrupted count cannot emit stale codes.
                        if (last_r || !nxt_any_s) begin
                            valid_r     <= 1'b0;
                            last_r      <= 1'b0;
                            remaining_r <= 5'd0;
                            state_r     <= ST_IDLE;
                        end else begin
                            code_r      <= nxt_idx_s;
                            remaining_r <= remaining_r - 5'd1;
                            last_r      <= (remaining_r == 5'd2);
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    valid_r <= 1'b0;
                    pend_r  <= 16'd0;
                end
            endcase
        end
    end

    assign bus.in_ready      = ~rst & (state_r == ST_IDLE);
    assign bus.out_code      = code_r;
    assign bus.out_valid     = valid_r;
    assign bus.out_last      = last_r;
    assign bus.out_remaining = remaining_r;
    assign bus.empty_pulse   = empty_r;

endmodule

// File: tb/tb_encoder_16x4_seq.sv
// Scoreboard bench for encoder_16x4_seq: directed vectors plus a decode round trip.
module tb_encoder_16x4_seq;

    typedef struct packed {
        logic [3:0] code;
        logic       last;
        logic [4:0] rem;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   rdy_mode = 0;

    exp_t        sb[$];
    logic [0:15] rt_q[$];
    logic [0:15] acc = 16'd0;

    always #5 clk = ~clk;

    encoder_16x4_seq_if bus ();

    encoder_16x4_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Consumer ready: 0 = always 1, 1 = always 0, 2 = pattern 1,0,0 repeating.
    initial begin
        int p;
        p = 0;
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'b0;
                default: bus.out_ready = (p % 3 == 0);
            endcase
            p++;
        end
    end

    // Monitor: compare every presented code against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_code: got code %0d with nothing expected at %0t", bus.out_code, $time);
            end else begin
                if (bus.out_code !== sb[0].code || bus.out_last !== sb[0].last || bus.out_remaining !== sb[0].rem) begin
                    n_err++;
                    $display("FAIL code_stream: got code %0d last %0b rem %0d, expected code %0d last %0b rem %0d at %0t",
                             bus.out_code, bus.out_last, bus.out_remaining, sb[0].code, sb[0].last, sb[0].rem, $time);
                end
                if (bus.out_ready) begin
                    void'(sb.pop_front());
                    acc[bus.out_code] = 1'b1;
                    if (bus.out_last) begin
                        n_vec++;
                        if (rt_q.size() == 0) begin
                            n_err++;
                            $display("FAIL round_trip: got %h with no vector pending", acc);
                        end else if (acc !== rt_q[0]) begin
                            n_err++;
                            $display("FAIL round_trip: got %h, expected %h", acc, rt_q[0]);
                        end
                        if (rt_q.size() != 0) void'(rt_q.pop_front());
                        acc = 16'd0;
                    end
                end
            end
        end
    end

    // Issue one vector; expected codes come from a bit scan of the vector.
    task automatic send(input logic [0:15] v);
        int rem;
        rem = 0;
        for (int i = 0; i < 16; i++) rem += int'(v[i]);
        for (int i = 0; i < 16; i++) begin
            if (v[i]) begin
                sb.push_back('{code: 4'(i), last: (rem == 1), rem: 5'(rem)});
                rem--;
            end
        end
        if (v != 16'd0) rt_q.push_back(v);
        @(posedge clk);
        #1;
        check("in_ready_before_send", 32'(bus.in_ready), 32'd1);
        bus.D        = v;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.D        = 16'($urandom);
        if (v != 16'd0) check("first_code_latency", 32'(bus.out_valid), 32'd1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((sb.size() != 0 || bus.in_ready !== 1'b1) && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("drain_timeout", 32'(k < 300), 32'd1);
    endtask

    initial begin
        logic [0:15] v;
        bus.D        = 16'd0;
        bus.in_valid = 1'b0;

        // Power-on reset values.
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_code", 32'(bus.out_code), 32'd0);
        check("rst_remaining", 32'(bus.out_remaining), 32'd0);
        check("rst_empty", 32'(bus.empty_pulse), 32'd0);
        check("rst_in_ready_low", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

        // Single line 9.
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        v = 16'd0; v[9] = 1'b1;
        send(v);
        @(posedge clk);
        #1;
        check("single_in_ready_next", 32'(bus.in_ready), 32'd1);
        check("single_valid_drop", 32'(bus.out_valid), 32'd0);
        drain();

        // Lines 1 and 14, consumer always ready.
        v = 16'd0; v[1] = 1'b1; v[14] = 1'b1;
        send(v);
        @(posedge clk);
        #1;
        check("multi_second_code", 32'(bus.out_code), 32'd14);
        check("multi_second_valid", 32'(bus.out_valid), 32'd1);
        drain();

        // All lines under backpressure.
        rdy_mode = 2;
        send(16'hFFFF);
        drain();
        rdy_mode = 0;

        // Zero vectors back to back.
        @(posedge clk);
        #1;
        bus.D        = 16'd0;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("zero_empty_pulse", 32'(bus.empty_pulse), 32'd1);
            check("zero_in_ready", 32'(bus.in_ready), 32'd1);
            if (k == 2) bus.in_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check("zero_pulse_ends", 32'(bus.empty_pulse), 32'd0);

        // Reset in the middle of {0,5,9} with the consumer stalled.
        rdy_mode = 1;
        repeat (2) @(posedge clk);
        v = 16'd0; v[0] = 1'b1; v[5] = 1'b1; v[9] = 1'b1;
        send(v);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        rt_q.delete();
        acc = 16'd0;
        #1;
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_out_code", 32'(bus.out_code), 32'd0);
        check("mid_rst_remaining", 32'(bus.out_remaining), 32'd0);
        check("mid_rst_last", 32'(bus.out_last), 32'd0);
        @(posedge clk);
        #1;
        check("mid_rst_in_ready_held", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        rdy_mode = 0;
        #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (6) @(posedge clk);

        // Round trip over random vectors, alternating consumer behaviour.
        for (int i = 0; i < 100; i++) begin
            rdy_mode = (i % 2 == 0) ? 0 : 2;
            send(16'($urandom));
            drain();
        end
        rdy_mode = 0;
        repeat (4) @(posedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        check("round_trip_queue_empty", 32'(rt_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
